// File: rtl/ram_reader.sv
// Sequential BRAM read engine: streams `length` words from `base_addr` out on a
// valid/ready interface through a 2-entry buffer that absorbs BRAM read latency.
module ram_reader #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [WIDTH-1:0]      mem_dout,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   rd_cnt;
  logic [ADDR_WIDTH:0]   beat_cnt;
  logic                  inflight;
  logic [WIDTH-1:0]      buf_mem [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            occ;
  logic                  pop;
  logic                  push;
  logic                  accept;
  logic [2:0]            occ_proj;
  logic [ADDR_WIDTH:0]   rd_cnt_nxt;
  logic [ADDR_WIDTH:0]   beat_cnt_nxt;

  assign out_valid    = (occ != 2'd0);
  assign pop          = out_valid & out_ready;
  assign push         = inflight;
  assign out_data     = buf_mem[rd_ptr];
  assign out_last     = out_valid & (beat_cnt == (len_q - {{ADDR_WIDTH{1'b0}}, 1'b1}));
  assign mem_addr     = base_q + rd_cnt[ADDR_WIDTH-1:0];
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  // Occupancy once this cycle's arriving word and departing beat are accounted for.
  assign occ_proj     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign rd_cnt_nxt   = rd_cnt + {{ADDR_WIDTH{1'b0}}, mem_rd_en};
  assign beat_cnt_nxt = beat_cnt + {{ADDR_WIDTH{1'b0}}, pop};

  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          // Zero-length requests pass through DRAIN so done lands two cycles after start.
          state_nxt = (length == '0) ? DRAIN : READ;
        end
      end
      READ: begin
        mem_rd_en = (rd_cnt < len_q) && (occ_proj < 3'd2);
        if (rd_cnt_nxt == len_q) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (beat_cnt_nxt == len_q) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      rd_cnt   <= '0;
      beat_cnt <= '0;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      occ      <= '0;
      for (int unsigned i = 0; i < 2; i++) buf_mem[i] <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= mem_rd_en;
      if (accept) begin
        base_q   <= base_addr;
        len_q    <= length;
        rd_cnt   <= '0;
        beat_cnt <= '0;
      end else begin
        rd_cnt   <= rd_cnt_nxt;
        beat_cnt <= beat_cnt_nxt;
      end
      if (push) begin
        buf_mem[wr_ptr] <= mem_dout;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
